// File: rtl/record_queue.sv
// Record FIFO of {kind, data, seq} with first-word fall-through and a sticky HALT on an illegal kind.
// Define RECORD_QUEUE_SEQ_EN to keep per-record sequence numbers; otherwise o_seq is tied to 0.
module record_queue #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_kind,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_kind,
    output logic [WIDTH-1:0] o_data,
    output logic [31:0]      o_seq,
    output logic [CW-1:0]    o_count,
    output logic [1:0]       o_state
);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2,
        HALT    = 2'd3
    } state_t;

`ifdef RECORD_QUEUE_SEQ_EN
    typedef struct packed {
        logic [1:0]       kind;
        logic [WIDTH-1:0] data;
        logic [31:0]      seq;
    } rec_t;
`else
    typedef struct packed {
        logic [1:0]       kind;
        logic [WIDTH-1:0] data;
    } rec_t;
`endif

    rec_t          mem_q [DEPTH];
    rec_t          wr_rec;
    rec_t          head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic          live_q;
    logic          push, pop, illegal;
`ifdef RECORD_QUEUE_SEQ_EN
    logic [31:0]   seq_q, seq_d;
`endif

    // live_q keeps o_ready low through reset and the first edge after release
    assign o_ready = live_q && (count_q < DEPTH_C) && (state_q != HALT);
    assign o_valid = (count_q != '0);
    assign push    = i_valid && o_ready && (i_kind != 2'd0);
    assign illegal = i_valid && o_ready && (i_kind == 2'd0);
    assign pop     = o_valid && i_ready;

    always_comb begin
        wr_rec      = '0;
        wr_rec.kind = i_kind;
        wr_rec.data = i_data;
`ifdef RECORD_QUEUE_SEQ_EN
        wr_rec.seq  = seq_q;
`endif
    end

    assign head    = mem_q[rd_ptr_q];
    assign o_kind  = head.kind;
    assign o_data  = head.data;
`ifdef RECORD_QUEUE_SEQ_EN
    assign o_seq   = head.seq;
`else
    assign o_seq   = 32'd0;
`endif
    assign o_count = count_q;
    assign o_state = state_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
`ifdef RECORD_QUEUE_SEQ_EN
        seq_d    = seq_q;
`endif
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = EMPTY;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
`ifdef RECORD_QUEUE_SEQ_EN
            if (push) seq_d = seq_q + 32'd1;
`endif
            // HALT is sticky; otherwise the state follows the post-update occupancy
            if (state_q == HALT || illegal) state_d = HALT;
            else if (count_d == '0)         state_d = EMPTY;
            else if (count_d == DEPTH_C)    state_d = FULL;
            else                            state_d = PARTIAL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= EMPTY;
            live_q   <= 1'b0;
`ifdef RECORD_QUEUE_SEQ_EN
            seq_q    <= 32'd0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            live_q   <= 1'b1;
`ifdef RECORD_QUEUE_SEQ_EN
            seq_q    <= seq_d;
`endif
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem_q[wr_ptr_q] <= wr_rec;
    end
endmodule

// File: tb/tb_record_queue.sv
// Directed bench for record_queue: stimulus pushes expected records into a scoreboard,
// a negedge monitor pops and compares every head the consumer accepts.
module tb_record_queue;
    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]       kind;
        logic [WIDTH-1:0] data;
        logic [31:0]      seq;
    } expRec_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic             flush;
    logic             inValid;
    logic             outReady;
    logic [1:0]       inKind;
    logic [WIDTH-1:0] inData;
    logic             outValid;
    logic             inReady;
    logic [1:0]       outKind;
    logic [WIDTH-1:0] outData;
    logic [31:0]      outSeq;
    logic [CW-1:0]    outCount;
    logic [1:0]       outState;

    expRec_t     sbQ[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] expSeq;

    record_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_flush (flush),
        .i_valid (inValid),
        .o_ready (outReady),
        .i_kind  (inKind),
        .i_data  (inData),
        .o_valid (outValid),
        .i_ready (inReady),
        .o_kind  (outKind),
        .o_data  (outData),
        .o_seq   (outSeq),
        .o_count (outCount),
        .o_state (outState)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seqOf(input logic [31:0] s);
`ifdef RECORD_QUEUE_SEQ_EN
        return s;
`else
        return 32'd0 & s;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] k, input logic [WIDTH-1:0] d,
                                 input logic r, input logic f);
        inValid = v;
        inKind  = k;
        inData  = d;
        inReady = r;
        flush   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic expectPush(input logic [1:0] k, input logic [WIDTH-1:0] d);
        sbQ.push_back({k, d, seqOf(expSeq)});
        expSeq = expSeq + 32'd1;
    endtask

    task automatic checkLevels(input string tag, input int cnt, input int st, input logic rdy);
        checkOutput({tag, ".count"}, 32'(outCount), 32'(cnt));
        checkOutput({tag, ".state"}, 32'(outState), 32'(st));
        checkOutput({tag, ".ready"}, 32'(outReady), 32'(rdy));
        checkOutput({tag, ".valid"}, 32'(outValid), 32'(cnt != 0));
    endtask

    // Monitor: a head accepted by the consumer must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (rstN && outValid && inReady && !flush) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL headUnexpected: got seq %0h data %0h want nothing", outSeq, outData);
            end else begin
                expRec_t e;
                e = sbQ.pop_front();
                checkOutput("head.kind", 32'(outKind), 32'(e.kind));
                checkOutput("head.data", 32'(outData), 32'(e.data));
                checkOutput("head.seq", outSeq, e.seq);
            end
        end
    end

    initial begin
        expSeq  = 32'd0;
        rstN    = 1'b0;
        flush   = 1'b0;
        inValid = 1'b0;
        inKind  = 2'd0;
        inData  = '0;
        inReady = 1'b0;
        #2;
        checkLevels("inReset", 0, 0, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        #2 rstN = 1'b1;
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        checkLevels("afterRelease", 0, 0, 1'b1);

        // Single push, visible next cycle, then popped
        expectPush(2'd1, 10'h155);
        applyStimulus(1'b1, 2'd1, 10'h155, 1'b0, 1'b0);
        checkLevels("firstPush", 1, 1, 1'b1);
        checkOutput("firstPush.seq", outSeq, seqOf(32'd0));
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);
        checkLevels("firstPop", 0, 0, 1'b1);

        // Fill to FULL, offer a fifth, then pop while offering
        expectPush(2'd2, 10'h001); applyStimulus(1'b1, 2'd2, 10'h001, 1'b0, 1'b0);
        expectPush(2'd3, 10'h3FF); applyStimulus(1'b1, 2'd3, 10'h3FF, 1'b0, 1'b0);
        expectPush(2'd1, 10'h2AA); applyStimulus(1'b1, 2'd1, 10'h2AA, 1'b0, 1'b0);
        expectPush(2'd2, 10'h0F0); applyStimulus(1'b1, 2'd2, 10'h0F0, 1'b0, 1'b0);
        checkLevels("full", 4, 2, 1'b0);
        applyStimulus(1'b1, 2'd3, 10'h123, 1'b0, 1'b0);
        checkLevels("fullOffer", 4, 2, 1'b0);
        applyStimulus(1'b1, 2'd3, 10'h123, 1'b1, 1'b0);
        checkLevels("fullPopBlocksPush", 3, 1, 1'b1);
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);
        checkLevels("downToTwo", 2, 1, 1'b1);

        // Steady push+pop at count 2, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            logic [1:0] k;
            k = 2'((i % 3) + 1);
            expectPush(k, 10'(10'h100 + i));
            applyStimulus(1'b1, k, 10'(10'h100 + i), 1'b1, 1'b0);
            checkOutput("stream.count", 32'(outCount), 32'd2);
        end

        // Flush at count 3 with push and pop requested; seq continues afterwards
        expectPush(2'd1, 10'h0AB);
        applyStimulus(1'b1, 2'd1, 10'h0AB, 1'b0, 1'b0);
        checkLevels("preFlush", 3, 1, 1'b1);
        applyStimulus(1'b1, 2'd2, 10'h3C3, 1'b1, 1'b1);
        sbQ.delete();
        checkLevels("flushed", 0, 0, 1'b1);
        expectPush(2'd1, 10'h05A);
        applyStimulus(1'b1, 2'd1, 10'h05A, 1'b0, 1'b0);
        checkOutput("seqAfterFlush", outSeq, seqOf(32'd16));
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);
        checkLevels("postFlushPop", 0, 0, 1'b1);

        // Illegal kind -> HALT, drains, only flush recovers
        expectPush(2'd1, 10'h011);
        applyStimulus(1'b1, 2'd1, 10'h011, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 10'h222, 1'b0, 1'b0);
        checkLevels("halt", 1, 3, 1'b0);
        applyStimulus(1'b1, 2'd1, 10'h044, 1'b0, 1'b0);
        checkLevels("haltBlocksPush", 1, 3, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);
        checkLevels("haltDrained", 0, 3, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b1);
        checkLevels("haltFlushed", 0, 0, 1'b1);
        expectPush(2'd1, 10'h033);
        applyStimulus(1'b1, 2'd1, 10'h033, 1'b0, 1'b0);
        checkOutput("seqAfterIllegal", outSeq, seqOf(32'd18));
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);

        // Reset in the middle of traffic discards everything and restarts seq
        expectPush(2'd2, 10'h101); applyStimulus(1'b1, 2'd2, 10'h101, 1'b0, 1'b0);
        expectPush(2'd3, 10'h202); applyStimulus(1'b1, 2'd3, 10'h202, 1'b0, 1'b0);
        checkOutput("preReset.count", 32'(outCount), 32'd2);
        inValid = 1'b1; inKind = 2'd1; inData = 10'h0EE; inReady = 1'b1;
        rstN = 1'b0;
        #1;
        sbQ.delete();
        expSeq = 32'd0;
        checkLevels("midReset", 0, 0, 1'b0);
        @(posedge clk);
        #2;
        inValid = 1'b0; inReady = 1'b0;
        rstN = 1'b1;
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        checkLevels("afterMidReset", 0, 0, 1'b1);
        expectPush(2'd1, 10'h155);
        applyStimulus(1'b1, 2'd1, 10'h155, 1'b0, 1'b0);
        checkOutput("seqAfterReset", outSeq, seqOf(32'd0));
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
